mem_stage: RTL and testbench
============================

# mem_stage

Memory-access pipeline stage between the E/M pipeline register and the M/WB pipeline register. It owns a small direct-mapped, write-through, no-write-allocate data cache and handles word loads and stores. It blocks on misses and store write-throughs through a small FSM and a line-based memory port. Results, exceptions and ROB ids are presented combinationally to the M/WB register in the same cycle an instruction completes.

## Interface
- WORD_SIZE, 32, data/address width
- INSTR_TYPE_SZ, 2, instruction type width
- ROB_ENTRY_WIDTH, 3, ROB id width
- TYPE_LOAD, 1, instruction_type encoding for loads
- TYPE_STORE, 2, instruction_type encoding for stores
- LINES, 4, cache lines (power of 2); line = 4 words = 128 bits
- clk  in  1  clock, rising edge
- reset  in  1  reset, synchronous, active-high
- valid_in  in  1  E/M holds a valid instruction
- instruction_type_in  in  INSTR_TYPE_SZ  type
- pc_in  in  WORD_SIZE  pass-through
- addr_in  in  WORD_SIZE  ALU result (effective address for load/store, result otherwise)
- store_data_in  in  WORD_SIZE  store data
- rob_id_in  in  ROB_ENTRY_WIDTH  pass-through
- stall_in  in  1  downstream (M/WB) cannot accept
- stall_out  out  1  hold E/M contents this cycle
- valid_out, instruction_type_out, pc_out, rob_id_out  out  1/INSTR_TYPE_SZ/WORD_SIZE/ROB_ENTRY_WIDTH  to M/WB
- aluResult_out  out  WORD_SIZE  load data, or addr_in for non-loads
- exception_out  out  1  misaligned load/store
- virtual_addr_exception_out  out  WORD_SIZE  faulting address, else 0
- mem_req  out  1  memory request (Moore, from state)
- mem_we  out  1  1 = word write, 0 = line read
- mem_addr  out  WORD_SIZE  read: line-aligned (addr[3:0]=0); write: word address
- mem_wdata  out  WORD_SIZE  store word
- mem_ready  in  1  request accepted/completed this cycle
- mem_rdata  in  128  fill line, valid with mem_ready on reads; word i = bits [32i+31:32i]

## Operation
- Address split: offset addr[3:2], index addr[3+log2(LINES):4], tag = remaining upper bits. Each line holds valid, tag and 4 words.
- Misaligned access: load or store with addr[1:0]≠0. Sets exception_out=1 and virtual_addr_exception_out=addr_in. No cache or memory access. Completes in IDLE like an ALU op.
- FSM states: IDLE, MISS_WAIT, STORE_WAIT, DONE.
- IDLE, valid_in=0: valid_out=0, stall_out=0.
- IDLE, ALU op, exception or load hit: valid_out=1, stall_out=stall_in. Load hit returns aluResult_out = cached word.
- IDLE, aligned load miss: valid_out=0, stall_out=1, next state MISS_WAIT.
- IDLE, aligned store: valid_out=0, stall_out=1, next state STORE_WAIT.
- MISS_WAIT: mem_req=1, mem_we=0, mem_addr={addr_in[31:4],4'b0}. On mem_ready: write line, set valid and tag, go to IDLE. valid_out=0, stall_out=1.
- STORE_WAIT: mem_req=1, mem_we=1, mem_addr=addr_in, mem_wdata=store_data_in. On mem_ready: if the line hits, update that word (no allocate on miss), go to DONE. valid_out=0, stall_out=1.
- DONE: valid_out=1, stall_out=stall_in, store is not reissued. Go to IDLE when stall_in=0.
- Upstream holds all *_in stable while stall_out=1.
- Outputs with valid_out=0 still pass the input fields through. M/WB ignores them.
- Reset: state IDLE, all line valid bits cleared, mem_req=0. Reset mid-MISS_WAIT or mid-STORE_WAIT abandons the request. Data arriving later on mem_ready is ignored. The external memory must tolerate the dropped request.
- reset dominates mem_ready in the same cycle.

## Timing
- ALU, exception and load hit: 0 added cycles, combinational through the stage.
- Load miss: miss seen in cycle 0. mem_req rises in cycle 1 and stays high until mem_ready is sampled in cycle k≥1. Fill happens at the end of cycle k. IDLE hit completes in cycle k+1. stall_out=1 for cycles 0..k.
- Store: mem_req in cycles 1..k. DONE in cycle k+1 presents valid_out=1. stall_out=1 for cycles 0..k, then follows stall_in.
- mem_req and mem_addr stay stable from assertion until mem_ready. mem_ready with mem_req=0 is ignored.
- A store to a line that is filled during the same request cannot occur, because there is one outstanding request.

## Test plan
- Reset, then load addr 0x100 with mem_ready returning after 3 cycles and rdata word0=0xDEADBEEF. Required: stall_out=1 for 4 cycles, mem_addr=0x100, then valid_out=1 with aluResult_out=0xDEADBEEF. A repeat load of 0x100 completes at once.
- ALU op with addr_in=0x1234, rob_id=5. Required: same-cycle valid_out=1, aluResult_out=0x1234, rob_id_out=5, no mem_req.
- Load from 0x102. Required: exception_out=1, virtual_addr_exception_out=0x102, valid_out=1, mem_req never asserted.
- Store 0xCAFEF00D to cached 0x104 with stall_in=1 during DONE for 2 cycles. Required: a single mem_we pulse sequence, valid_out held 2 extra cycles. A later load of 0x104 hits and returns 0xCAFEF00D.
- Store to uncached 0x200, then load 0x200. Required: no allocate on the store, so the load misses and issues a line read at 0x200.
- Reset asserted during MISS_WAIT, then mem_ready pulses. Required: state IDLE, mem_req=0, the stale fill is ignored, and a load of 0x100 misses again.

Source files
------------

// File: rtl/mem_stage_if.sv
// Line-based memory port of the memory-access stage: the stage issues line reads
// and word write-throughs, and the memory answers with mem_ready (plus a fill line on reads).
interface mem_stage_if #(
  parameter int WORD_SIZE = 32
);
  logic                     mem_req;
  logic                     mem_we;
  logic [WORD_SIZE-1:0]     mem_addr;
  logic [WORD_SIZE-1:0]     mem_wdata;
  logic                     mem_ready;
  logic [4*WORD_SIZE-1:0]   mem_rdata;

  modport master (output mem_req, mem_we, mem_addr, mem_wdata, input mem_ready, mem_rdata);
  modport slave  (input mem_req, mem_we, mem_addr, mem_wdata, output mem_ready, mem_rdata);
endinterface

// File: rtl/mem_stage.sv
// Memory-access pipeline stage with a direct-mapped, write-through, no-write-allocate
// data cache; blocks on load misses and store write-throughs.
module mem_stage #(
  parameter int                       WORD_SIZE       = 32,
  parameter int                       INSTR_TYPE_SZ   = 2,
  parameter int                       ROB_ENTRY_WIDTH = 3,
  parameter logic [INSTR_TYPE_SZ-1:0] TYPE_LOAD       = INSTR_TYPE_SZ'(1),
  parameter logic [INSTR_TYPE_SZ-1:0] TYPE_STORE      = INSTR_TYPE_SZ'(2),
  parameter int                       LINES           = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       valid_in,
  input  logic [INSTR_TYPE_SZ-1:0]   instruction_type_in,
  input  logic [WORD_SIZE-1:0]       pc_in,
  input  logic [WORD_SIZE-1:0]       addr_in,
  input  logic [WORD_SIZE-1:0]       store_data_in,
  input  logic [ROB_ENTRY_WIDTH-1:0] rob_id_in,
  input  logic                       stall_in,
  output logic                       stall_out,
  output logic                       valid_out,
  output logic [INSTR_TYPE_SZ-1:0]   instruction_type_out,
  output logic [WORD_SIZE-1:0]       pc_out,
  output logic [ROB_ENTRY_WIDTH-1:0] rob_id_out,
  output logic [WORD_SIZE-1:0]       aluResult_out,
  output logic                       exception_out,
  output logic [WORD_SIZE-1:0]       virtual_addr_exception_out,
  mem_stage_if.master                mem
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = WORD_SIZE - 4 - IDX_W;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    MISS_WAIT  = 2'd1,
    STORE_WAIT = 2'd2,
    DONE       = 2'd3
  } state_t;

  state_t                          state_r;
  logic                            mem_req_r;
  logic                            mem_we_r;
  logic                            line_valid_r [LINES];
  logic [TAG_W-1:0]                line_tag_r   [LINES];
  logic [3:0][WORD_SIZE-1:0]       line_data_r  [LINES];

  logic [IDX_W-1:0]     index_s;
  logic [TAG_W-1:0]     tag_s;
  logic [1:0]           offset_s;
  logic                 is_load_s;
  logic                 is_store_s;
  logic                 misaligned_s;
  logic                 hit_s;
  logic                 fill_s;
  logic                 store_upd_s;
  logic [WORD_SIZE-1:0] hit_word_s;

  assign index_s      = addr_in[4 +: IDX_W];
  assign tag_s        = addr_in[WORD_SIZE-1 -: TAG_W];
  assign offset_s     = addr_in[3:2];
  assign is_load_s    = (instruction_type_in == TYPE_LOAD);
  assign is_store_s   = (instruction_type_in == TYPE_STORE);
  assign misaligned_s = (is_load_s | is_store_s) & (addr_in[1:0] != 2'b00);
  assign hit_s        = line_valid_r[index_s] & (line_tag_r[index_s] == tag_s);
  assign hit_word_s   = line_data_r[index_s][offset_s];

  // Reset wins over mem_ready so a response landing on the reset cycle never fills.
  assign fill_s      = (state_r == MISS_WAIT)  & mem.mem_ready & ~reset;
  assign store_upd_s = (state_r == STORE_WAIT) & mem.mem_ready & hit_s & ~reset;

  assign mem.mem_req   = mem_req_r;
  assign mem.mem_we    = mem_we_r;
  assign mem.mem_addr  = mem_we_r ? addr_in : {addr_in[WORD_SIZE-1:4], 4'b0000};
  assign mem.mem_wdata = store_data_in;

  assign instruction_type_out = instruction_type_in;
  assign pc_out               = pc_in;
  assign rob_id_out           = rob_id_in;

  // Control FSM; the memory request lines are registered Moore outputs of it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      mem_req_r <= 1'b0;
      mem_we_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (valid_in && !misaligned_s && is_load_s && !hit_s) begin
            state_r   <= MISS_WAIT;
            mem_req_r <= 1'b1;
            mem_we_r  <= 1'b0;
          end else if (valid_in && !misaligned_s && is_store_s) begin
            state_r   <= STORE_WAIT;
            mem_req_r <= 1'b1;
            mem_we_r  <= 1'b1;
          end
        end
        MISS_WAIT: begin
          if (mem.mem_ready) begin
            state_r   <= IDLE;
            mem_req_r <= 1'b0;
          end
        end
        STORE_WAIT: begin
          if (mem.mem_ready) begin
            state_r   <= DONE;
            mem_req_r <= 1'b0;
            mem_we_r  <= 1'b0;
          end
        end
        DONE: begin
          if (!stall_in) begin
            state_r <= IDLE;
          end
        end
        default: begin
          state_r   <= IDLE;
          mem_req_r <= 1'b0;
          mem_we_r  <= 1'b0;
        end
      endcase
    end
  end

  // Line valid bits and tags; only a completed fill allocates.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < LINES; i++) begin
        line_valid_r[i] <= 1'b0;
      end
    end else if (fill_s) begin
      line_valid_r[index_s] <= 1'b1;
      line_tag_r[index_s]   <= tag_s;
    end
  end

  // Line data: whole-line fill on a miss, single-word update on a store hit.
  always_ff @(posedge clk) begin
    if (fill_s) begin
      line_data_r[index_s] <= mem.mem_rdata;
    end else if (store_upd_s) begin
      line_data_r[index_s][offset_s] <= store_data_in;
    end
  end

  // Completion, stall and exception outputs presented to the M/WB register.
  always_comb begin
    valid_out                  = 1'b0;
    stall_out                  = 1'b0;
    aluResult_out              = addr_in;
    exception_out              = 1'b0;
    virtual_addr_exception_out = {WORD_SIZE{1'b0}};
    case (state_r)
      IDLE: begin
        if (!valid_in) begin
          stall_out = 1'b0;
        end else if (misaligned_s) begin
          valid_out                  = 1'b1;
          stall_out                  = stall_in;
          exception_out              = 1'b1;
          virtual_addr_exception_out = addr_in;
        end else if (!is_load_s && !is_store_s) begin
          valid_out = 1'b1;
          stall_out = stall_in;
        end else if (is_load_s && hit_s) begin
          valid_out     = 1'b1;
          stall_out     = stall_in;
          aluResult_out = hit_word_s;
        end else begin
          stall_out = 1'b1;
        end
      end
      MISS_WAIT, STORE_WAIT: begin
        stall_out = 1'b1;
      end
      DONE: begin
        valid_out = 1'b1;
        stall_out = stall_in;
      end
      default: begin
        stall_out = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: a line-presence cache model plus a word memory model
// predict every cycle; a negedge process compares the DUT against the prediction.
module tb_mem_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        valid_in;
  logic [1:0]  instruction_type_in;
  logic [31:0] pc_in;
  logic [31:0] addr_in;
  logic [31:0] store_data_in;
  logic [2:0]  rob_id_in;
  logic        stall_in;
  logic        stall_out;
  logic        valid_out;
  logic [1:0]  instruction_type_out;
  logic [31:0] pc_out;
  logic [2:0]  rob_id_out;
  logic [31:0] aluResult_out;
  logic        exception_out;
  logic [31:0] virtual_addr_exception_out;

  mem_stage_if #(.WORD_SIZE(32)) mif ();

  mem_stage dut (
    .clk                        (clk),
    .reset                      (reset),
    .valid_in                   (valid_in),
    .instruction_type_in        (instruction_type_in),
    .pc_in                      (pc_in),
    .addr_in                    (addr_in),
    .store_data_in              (store_data_in),
    .rob_id_in                  (rob_id_in),
    .stall_in                   (stall_in),
    .stall_out                  (stall_out),
    .valid_out                  (valid_out),
    .instruction_type_out       (instruction_type_out),
    .pc_out                     (pc_out),
    .rob_id_out                 (rob_id_out),
    .aluResult_out              (aluResult_out),
    .exception_out              (exception_out),
    .virtual_addr_exception_out (virtual_addr_exception_out),
    .mem                        (mif)
  );

  int checks = 0;
  int errors = 0;

  logic        chk_en = 1'b0;
  logic        exp_valid, exp_stall, exp_req, exp_we, exp_exc, lit_en;
  logic [31:0] exp_addr, exp_result, exp_vexc, lit_val;
  int          stall_run = 0;
  int          last_run = 0;
  int          req_rises = 0;
  logic        prev_req = 1'b0;

  // Reference state: backing memory by word address, and which line each index holds.
  logic [31:0] mem_m [logic [31:0]];
  logic [31:0] cline [4];
  bit          cval  [4];

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem_m.exists(a)) return mem_m[a];
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (stall_out === 1'b1 && valid_out === 1'b0) begin
      stall_run <= stall_run + 1;
    end else begin
      if (stall_run != 0) last_run <= stall_run;
      stall_run <= 0;
    end
    if (mif.mem_req === 1'b1 && prev_req !== 1'b1) req_rises <= req_rises + 1;
    prev_req <= mif.mem_req;
    if (chk_en) begin
      check("valid_out", 32'(valid_out), 32'(exp_valid));
      check("stall_out", 32'(stall_out), 32'(exp_stall));
      check("mem_req", 32'(mif.mem_req), 32'(exp_req));
      check("pc_out", pc_out, pc_in);
      check("rob_id_out", 32'(rob_id_out), 32'(rob_id_in));
      check("type_out", 32'(instruction_type_out), 32'(instruction_type_in));
      if (exp_req) begin
        check("mem_we", 32'(mif.mem_we), 32'(exp_we));
        check("mem_addr", mif.mem_addr, exp_addr);
        if (exp_we) check("mem_wdata", mif.mem_wdata, store_data_in);
      end
      if (exp_valid) begin
        check("exception_out", 32'(exception_out), 32'(exp_exc));
        check("vaddr_exception", virtual_addr_exception_out, exp_vexc);
        if (!exp_exc) check("aluResult_out", aluResult_out, exp_result);
      end
      if (lit_en) check("literal_result", aluResult_out, lit_val);
    end
  end

  // One instruction: k = cycle in which mem_ready answers, hold = stall_in cycles at completion.
  task automatic run_instr(input logic [1:0] ty, input logic [31:0] a, input logic [31:0] wd,
                           input logic [2:0] rob, input int k, input int hold,
                           input logic lit_on, input logic [31:0] lit);
    logic ld, st, mis, hit;
    logic [31:0] la;
    int idx;
    ld  = (ty == 2'd1);
    st  = (ty == 2'd2);
    mis = (ld || st) && (a[1:0] != 2'b00);
    idx = int'(a[5:4]);
    la  = {a[31:4], 4'b0000};
    hit = cval[idx] && (cline[idx] == la);
    valid_in = 1'b1; instruction_type_in = ty; addr_in = a; store_data_in = wd;
    rob_id_in = rob; pc_in = 32'h4000_0000 + a; stall_in = 1'b0; mif.mem_ready = 1'b0;
    exp_exc = mis; exp_vexc = mis ? a : 32'h0; exp_req = 1'b0; exp_we = 1'b0; exp_addr = 32'h0;
    if ((ld || st) && !mis && !(ld && hit)) begin
      exp_valid = 1'b0; exp_stall = 1'b1;
      step();
      for (int c = 1; c <= k; c++) begin
        exp_req = 1'b1; exp_we = st; exp_addr = st ? a : la;
        mif.mem_ready = (c == k);
        mif.mem_rdata = {mem_rd(la + 32'd12), mem_rd(la + 32'd8), mem_rd(la + 32'd4), mem_rd(la)};
        step();
      end
      mif.mem_ready = 1'b0; exp_req = 1'b0; exp_we = 1'b0;
      if (ld) begin
        cval[idx] = 1'b1; cline[idx] = la;
      end else begin
        mem_m[a] = wd;
      end
    end
    exp_result = ld ? mem_rd(a) : a;
    lit_en = lit_on; lit_val = lit;
    for (int d = 0; d < hold; d++) begin
      stall_in = 1'b1; exp_valid = 1'b1; exp_stall = 1'b1;
      step();
    end
    stall_in = 1'b0; exp_valid = 1'b1; exp_stall = 1'b0;
    step();
    lit_en = 1'b0; valid_in = 1'b0; exp_valid = 1'b0; exp_stall = 1'b0;
    exp_exc = 1'b0; exp_vexc = 32'h0;
    step();
  endtask

  initial begin
    int r0;
    reset = 1'b1; valid_in = 1'b0; instruction_type_in = 2'd0; pc_in = 32'h0; addr_in = 32'h0;
    store_data_in = 32'h0; rob_id_in = 3'd0; stall_in = 1'b0;
    mif.mem_ready = 1'b0; mif.mem_rdata = 128'h0;
    exp_valid = 1'b0; exp_stall = 1'b0; exp_req = 1'b0; exp_we = 1'b0; exp_exc = 1'b0;
    exp_addr = 32'h0; exp_result = 32'h0; exp_vexc = 32'h0; lit_en = 1'b0; lit_val = 32'h0;
    mem_m[32'h100] = 32'hDEADBEEF;
    for (int i = 0; i < 4; i++) begin cval[i] = 1'b0; cline[i] = 32'h0; end
    step(); step();
    reset = 1'b0; chk_en = 1'b1;
    step(); step();

    // Cold miss at 0x100, then an immediate hit on the same word.
    run_instr(2'd1, 32'h100, 32'h0, 3'd1, 3, 0, 1'b1, 32'hDEADBEEF);
    check("miss_stall_cycles", 32'(last_run), 32'd4);
    run_instr(2'd1, 32'h100, 32'h0, 3'd1, 0, 0, 1'b1, 32'hDEADBEEF);

    // ALU ops, one of them held by stall_in; unaligned address is not an exception for ALU.
    run_instr(2'd0, 32'h1234, 32'h0, 3'd5, 0, 0, 1'b1, 32'h1234);
    run_instr(2'd3, 32'h1235, 32'h0, 3'd6, 0, 1, 1'b1, 32'h1235);

    // Misaligned load and store.
    run_instr(2'd1, 32'h102, 32'h0, 3'd2, 0, 0, 1'b0, 32'h0);
    run_instr(2'd2, 32'h107, 32'h55, 3'd2, 0, 0, 1'b0, 32'h0);

    // Store hit with a two-cycle downstream stall, then read it back.
    r0 = req_rises;
    run_instr(2'd2, 32'h104, 32'hCAFEF00D, 3'd3, 2, 2, 1'b0, 32'h0);
    check("store_req_bursts", 32'(req_rises - r0), 32'd1);
    run_instr(2'd1, 32'h104, 32'h0, 3'd3, 0, 0, 1'b1, 32'hCAFEF00D);

    // Store miss does not allocate; the following load of 0x200 must fetch the line.
    run_instr(2'd2, 32'h200, 32'h11223344, 3'd4, 1, 0, 1'b0, 32'h0);
    run_instr(2'd1, 32'h200, 32'h0, 3'd4, 2, 0, 1'b1, 32'h11223344);
    run_instr(2'd1, 32'h20C, 32'h0, 3'd7, 0, 1, 1'b0, 32'h0);
    run_instr(2'd1, 32'h118, 32'h0, 3'd0, 1, 0, 1'b0, 32'h0);

    // Reset during MISS_WAIT with mem_ready on the reset cycle and after it.
    valid_in = 1'b1; instruction_type_in = 2'd1; addr_in = 32'h100; pc_in = 32'h4000_0100;
    rob_id_in = 3'd2; exp_valid = 1'b0; exp_stall = 1'b1; exp_req = 1'b0;
    step();
    exp_req = 1'b1; exp_we = 1'b0; exp_addr = 32'h100;
    step();
    reset = 1'b1; mif.mem_ready = 1'b1; mif.mem_rdata = {4{32'hBAD0BAD0}};
    step();
    reset = 1'b0; valid_in = 1'b0; exp_stall = 1'b0; exp_req = 1'b0;
    step();
    mif.mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) cval[i] = 1'b0;
    step();
    run_instr(2'd1, 32'h100, 32'h0, 3'd1, 2, 0, 1'b1, 32'hDEADBEEF);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
